// File: rtl/cnt_cmd_driver_if.sv
// Request/response and counter-strobe bundle for cnt_cmd_driver.
// master = the driver, slave = the environment (requester plus counter).
interface cnt_cmd_driver_if #(
   parameter int WIDTH = 3
);
   logic             req_valid;
   logic             req_ready;
   logic [WIDTH-1:0] req_start;
   logic [WIDTH-1:0] req_num;
   logic             ld;
   logic             inc;
   logic [WIDTH-1:0] data_in;
   logic [WIDTH-1:0] cnt_value;
   logic             done;
   logic [1:0]       status;
   logic [WIDTH-1:0] result;

   modport master (
      input  req_valid, req_start, req_num, cnt_value,
      output req_ready, ld, inc, data_in, done, status, result
   );

   modport slave (
      output req_valid, req_start, req_num, cnt_value,
      input  req_ready, ld, inc, data_in, done, status, result
   );
endinterface

// File: rtl/cnt_cmd_driver.sv
// Command master for a load/increment counter: loads a start value, issues
// verified single-cycle increments, refuses overflow, reports a status code.
module cnt_cmd_driver #(
   parameter int WIDTH = 3
) (
   input  logic              clk,
   input  logic              rst,
   cnt_cmd_driver_if.master  bus
);

   typedef enum logic [2:0] {S_IDLE, S_LOAD, S_CHECK, S_INC, S_DONE} state_e;

   localparam logic [1:0] ST_OK   = 2'b00;
   localparam logic [1:0] ST_OVF  = 2'b01;
   localparam logic [1:0] ST_MISM = 2'b10;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] exp_q, exp_d;
   logic [WIDTH-1:0] rem_q, rem_d;
   logic [WIDTH-1:0] data_in_q, data_in_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic [1:0]       status_q, status_d;
   logic             ld_q, ld_d;
   logic             inc_q, inc_d;
   logic             done_q, done_d;

   logic mismatch, at_max;
   assign mismatch = (bus.cnt_value != exp_q);
   assign at_max   = (exp_q == {WIDTH{1'b1}});

   // state register
   always_ff @(posedge clk) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   // next state
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (bus.req_valid) state_d = S_LOAD;
         S_LOAD:  state_d = S_CHECK;
         S_CHECK: if (mismatch || rem_q == '0 || at_max) state_d = S_DONE;
                  else                                  state_d = S_INC;
         S_INC:   state_d = S_CHECK;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Strobes are registered, so they are decoded from the state being entered.
   always_comb begin
      ld_d      = (state_d == S_LOAD);
      inc_d     = (state_d == S_INC);
      done_d    = (state_d == S_DONE);
      exp_d     = exp_q;
      rem_d     = rem_q;
      data_in_d = data_in_q;
      status_d  = status_q;
      result_d  = result_q;
      case (state_q)
         S_IDLE: if (bus.req_valid) begin
            exp_d     = bus.req_start;
            rem_d     = bus.req_num;
            data_in_d = bus.req_start;
         end
         S_CHECK: if (state_d == S_DONE) begin
            result_d = bus.cnt_value;
            if (mismatch)        status_d = ST_MISM;
            else if (rem_q == '0) status_d = ST_OK;
            else                 status_d = ST_OVF;
         end
         S_INC: begin
            exp_d = exp_q + 1'b1;
            rem_d = rem_q - 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         exp_q     <= '0;
         rem_q     <= '0;
         data_in_q <= '0;
         status_q  <= ST_OK;
         result_q  <= '0;
         ld_q      <= 1'b0;
         inc_q     <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         exp_q     <= exp_d;
         rem_q     <= rem_d;
         data_in_q <= data_in_d;
         status_q  <= status_d;
         result_q  <= result_d;
         ld_q      <= ld_d;
         inc_q     <= inc_d;
         done_q    <= done_d;
      end
   end

   assign bus.req_ready = (state_q == S_IDLE);
   assign bus.ld        = ld_q;
   assign bus.inc       = inc_q;
   assign bus.data_in   = data_in_q;
   assign bus.done      = done_q;
   assign bus.status    = status_q;
   assign bus.result    = result_q;

endmodule

// File: doc/cnt_cmd_driver.md
Name: cnt_cmd_driver

Overview:
- Command-side master for the load/increment counter interface. It is the block that drives `ld`, `inc` and `data_in` into a WIDTH-bit loadable counter, and it reads back the counter's `data_out`.
- Accepts a request {start value, increment count} over a valid/ready handshake, loads the counter, then issues single-cycle increment pulses.
- Checks the counter's value after every operation and never issues an increment that would overflow it.
- Reports completion with a status code; sits between test/control logic and the counter instance.

Parameters:
- WIDTH, 3, counter width in bits; also the width of the requested increment count.

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst  input  1  reset, synchronous, active-high; shared with the driven counter.
- req_valid  input  1  request present.
- req_ready  output  1  block can accept a request (high only in IDLE).
- req_start  input  WIDTH  value to load into the counter.
- req_num  input  WIDTH  number of increments to issue (0 allowed).
- ld  output  1  load strobe to counter.
- inc  output  1  increment strobe to counter.
- data_in  output  WIDTH  load value to counter.
- cnt_value  input  WIDTH  counter's registered data_out.
- done  output  1  one-cycle completion pulse.
- status  output  2  valid with done: 00 ok, 01 overflow refused, 10 readback mismatch.
- result  output  WIDTH  last checked counter value; held until the next done.

Behaviour:
- Reset values:
  - state = IDLE; ld = inc = done = 0; status = 00; result = 0; data_in = 0.
  - Internal expected/remaining registers = 0.
  - Reset in any state aborts the operation immediately; no done pulse is produced.
- Registers and outputs:
  - ld, inc, done, status, result and data_in are all registered.
  - ld and inc are never high in the same cycle.
  - ld, inc and done are never high for more than one consecutive cycle.
- IDLE:
  - req_ready = 1.
  - On req_valid && req_ready: capture expected = req_start and remaining = req_num, drive data_in = req_start, go to LOAD.
  - req_valid while not in IDLE is ignored; there is no queueing.
- LOAD (1 cycle): ld = 1 with data_in stable, then go to CHECK.
- CHECK (1 cycle, counter has registered the previous strobe):
  - If cnt_value != expected: status = 10 and go to DONE (mismatch has priority).
  - Else if remaining == 0: status = 00 and go to DONE.
  - Else if expected == 2^WIDTH-1: status = 01 and go to DONE; no inc is issued.
  - Else go to INC.
- INC (1 cycle): inc = 1; expected = expected + 1; remaining = remaining - 1; go to CHECK.
- DONE (1 cycle):
  - done = 1; result = cnt_value as sampled in the final CHECK; status holds the code decided there.
  - Return to IDLE.
  - req_ready goes high again in the cycle after done.
- Latency:
  - Handshake accepted at edge E0 → ld high in cycle 1, CHECK in cycle 2, each increment costs 2 cycles.
  - done is high in cycle 3 + 2N for N successful increments.
- Arithmetic:
  - expected is WIDTH bits and is never incremented past 2^WIDTH-1, because the overflow check precedes INC.
  - req_num = 0 performs a load-and-verify only.
- data_in holds the captured start value until the next accepted request.

Test Plan:
- Reset, then req_start = 2, req_num = 3 with a 3-bit counter attached → one ld pulse, then 3 inc pulses spaced 2 cycles apart; done in cycle 9 after acceptance with status = 00, result = 5.
- req_start = 5, req_num = 4 → inc pulses take the counter to 6 and 7; the third increment is refused; done with status = 01, result = 7; no inc is ever asserted while cnt_value == 7.
- req_start = 6, req_num = 0 → ld only, no inc; done in cycle 3 with status = 00, result = 6.
- Counter model forced to return 3 after loading 4 (req_start = 4, req_num = 2) → no inc issued; done with status = 10, result = 3.
- Assert rst during the second INC of req_start = 0, req_num = 5 → the next cycle shows ld = inc = done = 0, req_ready = 1, result = 0, and there is no done pulse. A new request (1, 1) then completes with status = 00, result = 2.
- Hold req_valid high continuously with changing req_start → requests are accepted only in IDLE (one per operation); values presented during an operation are ignored.
